// File: rtl/prio_arb_encoder_pkg.sv
// prio_arb_encoder_pkg
//   Shared types and helpers for the registered priority arbiter/encoder.
//   - state_e : output FSM states (IDLE = nothing presented, HOLD = winner presented)
//   - clog2   : constant function used to size the winner index
package prio_arb_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Ceiling log2, valid for v >= 2 (the legal request-count range).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_arb_encoder_rot_search.sv
// prio_rot_search
//   Combinational search of a request vector starting from a priority pointer.
//   The scan order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set bit wins.
//   Ports:
//     req   [N-1:0] : request vector
//     ptr   [W-1:0] : index that has highest priority (always < N)
//     found         : at least one request is set
//     idx   [W-1:0] : winning index (0 when nothing is found)
module prio_rot_search #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Rotated bit j holds original line (ptr + 1 + j) mod N, which puts the
    // pointer line at the MSB and ptr+1 at the LSB. An MSB-first scan of the
    // rotated vector therefore walks ptr downward with wraparound.
    function automatic logic [W-1:0] unrot(input logic [W-1:0] p, input int j);
        int s;
        s = int'(p) + 1 + j;
        if (s >= N) begin
            s = s - N;
        end
        return W'(s);
    endfunction

    logic [N-1:0] rot;
    int           sel;

    always_comb begin
        rot = '0;
        for (int j = 0; j < N; j++) begin
            rot[j] = req[unrot(ptr, j)];
        end
    end

    // Ascending loop with last-hit-wins gives the highest set rotated bit.
    always_comb begin
        found = 1'b0;
        sel   = 0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
    end

    always_comb begin
        idx = '0;
        if (found) begin
            idx = unrot(ptr, sel);
        end
    end

endmodule

// File: rtl/prio_arb_encoder.sv
// prio_arb_encoder
//   Registered priority arbiter: picks one active request (fixed MSB-first or
//   round-robin) and presents it as a binary index plus one-hot grant behind a
//   valid/ready handshake.
//   Parameters:
//     N       : number of request lines (2..64)
//     RR_MODE : 0 = fixed priority (MSB highest), 1 = round-robin
//   Ports:
//     clk, rst          : rising-edge clock, synchronous active-high reset
//     req   [N-1:0]     : level-sensitive request vector
//     out_valid         : a winner is presented
//     out_ready         : consumer accepts the winner
//     out_idx [W-1:0]   : binary index of the winner
//     out_onehot[N-1:0] : one-hot grant (1 << out_idx while valid)
//     req_none          : req was all zero on the previous cycle
module prio_arb_encoder
    import prio_arb_encoder_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_MODE = 0,
    localparam int W      = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         req_none
);

    localparam logic [W-1:0] PTR_TOP = W'(N - 1);

    state_e       state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         req_none_q, req_none_d;

    logic         handshake;
    logic         found;
    logic [W-1:0] search_idx;

    assign handshake = (state_q == HOLD) && out_ready;

    // Pointer update is kept in its own process: the search below must see
    // the post-handshake pointer on the same edge, and mixing it with the FSM
    // process would create a false combinational cycle through the search.
    always_comb begin
        ptr_d = ptr_q;
        if ((RR_MODE != 0) && handshake) begin
            // Just-served line drops to lowest priority.
            ptr_d = (idx_q == '0) ? PTR_TOP : (idx_q - W'(1));
        end
    end

    prio_rot_search #(
        .N (N),
        .W (W)
    ) u_search (
        .req   (req),
        .ptr   (ptr_d),
        .found (found),
        .idx   (search_idx)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        onehot_d   = onehot_q;
        req_none_d = ~|req;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d    = search_idx;
                    onehot_d = N'(1) << search_idx;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                // No preemption while the consumer stalls; only a handshake
                // lets a new winner in.
                if (out_ready) begin
                    if (found) begin
                        idx_d    = search_idx;
                        onehot_d = N'(1) << search_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_TOP;
            idx_q      <= '0;
            onehot_q   <= '0;
            req_none_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            onehot_q   <= onehot_d;
            req_none_q <= req_none_d;
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign req_none   = req_none_q;

endmodule

// File: doc/prio_arb_encoder.md
# prio_arb_encoder

Parametrised, registered successor to the team's 8-bit combinational priority encoder. Samples an N-bit request vector, selects one active request by fixed priority (MSB highest) or round-robin, and presents the winner as a binary index plus one-hot grant behind a valid/ready handshake. It sits between request sources, such as interrupt lines or channel-ready flags, and a single downstream consumer that takes one winner at a time.

## Interface
- N, default 8: number of request lines; legal range 2..64.
- RR_MODE, default 0: 0 selects fixed priority with MSB highest; 1 selects round-robin.
- W, derived localparam equal to clog2(N): index width; not overridable.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, N: request vector, level-sensitive.
- out_valid, output, 1: a winner is presented.
- out_ready, input, 1: the consumer accepts the winner.
- out_idx, output, W: binary index of the winner.
- out_onehot, output, N: one-hot grant; equals 1 shifted left by out_idx while out_valid is high.
- req_none, output, 1: registered flag; high when req was all zero on the previous cycle.

## Operation
- Two states.
  - IDLE: out_valid is 0.
  - HOLD: out_valid is 1.
- Priority pointer ptr, W bits: index that wins first in the next search. The search scans ptr, ptr-1, …, 0, N-1, …, ptr+1, and the first set bit wins.
- Fixed mode: ptr is constantly N-1. This reproduces the legacy encoder's MSB-highest order.
- Round-robin mode: on each handshake with winner g, ptr is set to g-1, wrapping to N-1 when g=0. The just-served line becomes lowest priority.
- IDLE transitions:
  - req nonzero: load out_idx and out_onehot from the search result using the current ptr, then go to HOLD.
  - req zero: stay in IDLE. Outputs keep their last values; out_valid is 0.
- HOLD transitions:
  - out_ready=0: hold out_idx and out_onehot stable. No re-arbitration or preemption, even if a higher-priority request appears or the granted request drops.
  - out_ready=1 and req nonzero: a back-to-back grant. Search req with the post-update ptr and load the new winner; stay in HOLD.
  - out_ready=1 and req zero: go to IDLE.
- All-zero req never produces an X index, unlike the legacy default. Zero input simply yields out_valid=0.
- req_none is registered every cycle, independent of state.

## Timing
- Latency: req sampled at edge t gives out_valid and out_idx valid after edge t (visible in cycle t+1).
- Handshake: the transfer occurs on an edge where out_valid and out_ready are both 1. out_ready may be high while out_valid is 0; this has no effect.
- Throughput: one grant per cycle while out_ready is held high and req is nonzero.
- Round-robin ptr updates on the handshake edge. The search that uses the updated ptr is the one performed on that same edge.
- Reset values: out_valid=0, out_idx=0, out_onehot=0, req_none=1, ptr=N-1, state IDLE.
- Reset asserted mid-HOLD: outputs go to the reset values on that edge, and the pending winner is discarded. rst has priority over out_ready and req.
- Winner index N-1 at ptr=N-1 (a wrap): next ptr=N-2. Winner 0: next ptr=N-1.

## Structure
- A shared package holds:
  - the state enum (IDLE, HOLD);
  - a clog2 helper constant function used to derive W.
- One natural sub-module: prio_rot_search. It is combinational and takes req, ptr and N, and returns found and idx. It rotates req so ptr sits at the MSB, runs an MSB-first priority scan, and un-rotates the index.
- The top level holds the FSM, output registers and ptr register.

## Test plan
- Fixed mode, N=8: req=8'b0010_0110 with out_ready=1 → out_idx=5, out_onehot=8'h20 after one edge; grant repeats every cycle while req is held.
- Backpressure: HOLD with out_idx=5 and out_ready=0, then req changes to 8'h80 → out_idx stays 5 until out_ready=1; the next grant is 7.
- Round-robin, N=8: req=8'hFF held with out_ready=1 → grant sequence 7,6,5,4,3,2,1,0,7.
- Round-robin with sparse requests: req=8'b1000_0001 → grants alternate 7,0,7,0.
- Zero input: req=0 from reset → out_valid stays 0 and req_none=1; req=8'h01 → out_idx=0 and out_valid=1 one cycle later.
- Reset mid-HOLD, N=16, RR_MODE=1: rst pulsed while out_valid=1 → next cycle out_valid=0, out_idx=0, ptr=15. Afterwards req=16'hFFFF grants 15 first.
